// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element constants for the single-port SRAM self-test.
// Element bit vectors are indexed by element number 0..5; bits 6..7 are unused padding.
package sram_bist_pkg;

  localparam int ELEM_IDX_W = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } march_state_e;

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
  localparam logic [7:0] ELEM_DIR_DOWN = 8'b0001_1000;
  localparam logic [7:0] ELEM_HAS_RD   = 8'b0011_1110;
  localparam logic [7:0] ELEM_RD_VAL   = 8'b0001_0100;
  localparam logic [7:0] ELEM_HAS_WR   = 8'b0001_1111;
  localparam logic [7:0] ELEM_WR_VAL   = 8'b0000_1010;
  localparam logic [7:0] ELEM_TWO_OPS  = 8'b0001_1110;

  function automatic logic [ELEM_IDX_W-1:0] elem_idx(input march_state_e s);
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_march(input march_state_e s);
    return (s == S_M0) || (s == S_M1) || (s == S_M2) ||
           (s == S_M3) || (s == S_M4) || (s == S_M5);
  endfunction

endpackage

// File: rtl/sram_march_engine.sv
// March C- sequencer: FSM, address walk, read/write phasing, pipelined compare, sticky flags.
// SRAM_BIST_FAIL_LOG_EN adds a first-mismatch address/element log.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no test since reset; waiting for start
// S_M0    | up(w0)
// S_M1    | up(r0,w1)
// S_M2    | up(r1,w0)
// S_M3    | down(r0,w1)
// S_M4    | down(r1,w0)
// S_M5    | up(r0)
// S_DRAIN | one cycle for the final read's compare
// S_DONE  | finished; done/fail held until next start
module sram_march_engine
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [P_DATA_WIDTH-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic                    men,
  output logic                    wen,
  output logic                    ren,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic [P_DATA_WIDTH-1:0] din,
  output logic [P_DATA_WIDTH-1:0] bm
`ifdef SRAM_BIST_FAIL_LOG_EN
  ,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [ELEM_IDX_W-1:0]   fail_elem
`endif
);

  march_state_e            state;
  march_state_e            next_elem_state;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_ADDR_WIDTH-1:0] left_q;
  logic                    phase;
  logic                    rd_pend;
  logic                    rd_exp;
  logic [ELEM_IDX_W-1:0]   cur_elem;
  logic                    in_march;
  logic                    last_op;
  logic                    next_down;
  logic                    mismatch;
`ifdef SRAM_BIST_FAIL_LOG_EN
  logic [P_ADDR_WIDTH-1:0] rd_addr_q;
  logic [ELEM_IDX_W-1:0]   rd_elem_q;
`endif

  always_comb begin
    cur_elem        = elem_idx(state);
    in_march        = is_march(state);
    next_elem_state = march_state_e'(state + 4'd1);
    next_down       = ELEM_DIR_DOWN[elem_idx(next_elem_state)];
    last_op         = !ELEM_TWO_OPS[cur_elem] || phase;
    men             = in_march;
    ren             = in_march && ELEM_HAS_RD[cur_elem] && (!ELEM_TWO_OPS[cur_elem] || !phase);
    wen             = in_march && ELEM_HAS_WR[cur_elem] && (!ELEM_TWO_OPS[cur_elem] || phase);
    addr            = addr_q;
    din             = {P_DATA_WIDTH{ELEM_WR_VAL[cur_elem]}};
    bm              = {P_DATA_WIDTH{1'b1}};
    mismatch        = rd_pend && (rd_data != {P_DATA_WIDTH{rd_exp}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      addr_q  <= '0;
      left_q  <= '0;
      phase   <= 1'b0;
      rd_pend <= 1'b0;
      rd_exp  <= 1'b0;
`ifdef SRAM_BIST_FAIL_LOG_EN
      rd_addr_q <= '0;
      rd_elem_q <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
`endif
    end else begin
      rd_pend <= 1'b0;
      if (mismatch) begin
        fail <= 1'b1;
`ifdef SRAM_BIST_FAIL_LOG_EN
        if (!fail) begin
          fail_addr <= rd_addr_q;
          fail_elem <= rd_elem_q;
        end
`endif
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_M0;
            busy   <= 1'b1;
            done   <= 1'b0;
            fail   <= 1'b0;
            addr_q <= '0;
            left_q <= '1;
            phase  <= 1'b0;
`ifdef SRAM_BIST_FAIL_LOG_EN
            fail_addr <= '0;
            fail_elem <= '0;
`endif
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          if (ren) begin
            rd_pend <= 1'b1;
            rd_exp  <= ELEM_RD_VAL[cur_elem];
`ifdef SRAM_BIST_FAIL_LOG_EN
            rd_addr_q <= addr_q;
            rd_elem_q <= cur_elem;
`endif
          end
          if (!last_op) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            // left_q counts remaining addresses; terminal count ends the element
            if (left_q == '0) begin
              state  <= next_elem_state;
              left_q <= '1;
              addr_q <= next_down ? '1 : '0;
            end else begin
              left_q <= left_q - P_ADDR_WIDTH'(1);
              addr_q <= ELEM_DIR_DOWN[cur_elem] ? addr_q - P_ADDR_WIDTH'(1)
                                                : addr_q + P_ADDR_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_1p_bm_selftest.sv
// Single-port bit-masked SRAM model with built-in March C- self-test.
// SRAM_BIST_FAIL_LOG_EN exposes the first failing address and element.
module sram_1p_bm_selftest
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  input  logic                    A_BIST_START,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL
`ifdef SRAM_BIST_FAIL_LOG_EN
  ,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR,
  output logic [ELEM_IDX_W-1:0]   A_BIST_FAIL_ELEM
`endif
);

  localparam int DEPTH = 2 ** P_ADDR_WIDTH;

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];

  logic                    bist_men;
  logic                    bist_wen;
  logic                    bist_ren;
  logic [P_ADDR_WIDTH-1:0] bist_addr;
  logic [P_DATA_WIDTH-1:0] bist_din;
  logic [P_DATA_WIDTH-1:0] bist_bm;
  logic [P_DATA_WIDTH-1:0] bist_rd_q;

  logic                    m_men;
  logic                    m_wen;
  logic                    m_ren;
  logic [P_ADDR_WIDTH-1:0] m_addr;
  logic [P_DATA_WIDTH-1:0] m_din;
  logic [P_DATA_WIDTH-1:0] m_bm;

  sram_march_engine #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_engine (
    .clk      (A_CLK),
    .rst_n    (A_RST_N),
    .start    (A_BIST_START),
    .rd_data  (bist_rd_q),
    .busy     (A_BIST_BUSY),
    .done     (A_BIST_DONE),
    .fail     (A_BIST_FAIL),
    .men      (bist_men),
    .wen      (bist_wen),
    .ren      (bist_ren),
    .addr     (bist_addr),
    .din      (bist_din),
    .bm       (bist_bm)
`ifdef SRAM_BIST_FAIL_LOG_EN
    ,
    .fail_addr(A_BIST_FAIL_ADDR),
    .fail_elem(A_BIST_FAIL_ELEM)
`endif
  );

  // The engine owns the array for the whole busy window; SoC requests are dropped.
  always_comb begin
    if (A_BIST_BUSY) begin
      m_men  = bist_men;
      m_wen  = bist_wen;
      m_ren  = bist_ren;
      m_addr = bist_addr;
      m_din  = bist_din;
      m_bm   = bist_bm;
    end else begin
      m_men  = A_MEN;
      m_wen  = A_WEN;
      m_ren  = A_REN;
      m_addr = A_ADDR;
      m_din  = A_DIN;
      m_bm   = A_BM;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge A_CLK) begin
    if (m_men && m_wen) begin
      mem[m_addr] <= (mem[m_addr] & ~m_bm) | (m_din & m_bm);
    end
  end

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      A_DOUT    <= '0;
      bist_rd_q <= '0;
    end else if (m_men && m_ren && !m_wen) begin
      if (A_BIST_BUSY) begin
        bist_rd_q <= mem[m_addr];
      end else begin
        A_DOUT <= mem[m_addr];
      end
    end
  end

endmodule
